// File: rtl/pattern_scheduler_pkg.sv
// Shared definitions for the pattern scheduler.
//   - sched_state_t : scheduler FSM state encoding
//   - CMD_W_DEFAULT : default command word width
//   - SCORE_W       : width of the saturating hit counter
//   - popcount8     : counts set bits of an up-to-8-bit lane vector
package pattern_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARB     = 3'd1,
        ST_READ    = 3'd2,
        ST_LOAD    = 3'd3,
        ST_DELIVER = 3'd4,
        ST_DONE    = 3'd5
    } sched_state_t;

    localparam int CMD_W_DEFAULT = 4;
    localparam int SCORE_W       = 16;

    // Number of set bits in an 8-bit vector; lane vectors are zero-extended to 8 bits.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/pattern_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter for the pattern lanes.
// Searches the pending vector upward from rr_ptr, wrapping at NUM_LANES.
// Ports:
//   pending      in  NUM_LANES  lanes waiting for a command
//   rr_ptr       in  PTR_W      lane with highest priority this round
//   grant_onehot out NUM_LANES  one-hot winner (zero when nothing pending)
//   grant_idx    out PTR_W      index of the winner
//   any_req      out 1          at least one lane pending
module pattern_scheduler_rr_arbiter #(
    parameter int NUM_LANES = 3,
    parameter int PTR_W     = $clog2(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] pending,
    input  logic [PTR_W-1:0]     rr_ptr,
    output logic [NUM_LANES-1:0] grant_onehot,
    output logic [PTR_W-1:0]     grant_idx,
    output logic                 any_req
);

    // Priority search starting at rr_ptr; the first pending lane found wins.
    always_comb begin
        logic             w_found;
        logic [PTR_W:0]   w_sum;
        logic [PTR_W-1:0] w_idx;
        grant_onehot = '0;
        grant_idx    = '0;
        w_found      = 1'b0;
        w_sum        = '0;
        w_idx        = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            // rr_ptr is always below NUM_LANES, so one subtraction wraps it
            if (w_sum >= (PTR_W+1)'(NUM_LANES)) begin
                w_sum = w_sum - (PTR_W+1)'(NUM_LANES);
            end else begin
                w_sum = w_sum;
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!w_found && pending[w_idx]) begin
                w_found             = 1'b1;
                grant_idx           = w_idx;
                grant_onehot[w_idx] = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
        any_req = |pending;
    end

endmodule

// File: rtl/pattern_scheduler.sv
// Pattern scheduler: hands the shared command list out to the falling-note
// lanes one command at a time, round-robin, reading a synchronous ROM.
// Ports:
//   CLOCK_25     in  1          system clock
//   reset_n      in  1          synchronous active-low reset
//   start        in  1          begin/restart a game (IDLE or DONE only)
//   req          in  NUM_LANES  per-lane request pulses (pattern left screen)
//   ponto        in  NUM_LANES  per-lane hit pulses
//   rom_addr     out ADDR_W     registered ROM address
//   rom_data     in  CMD_W      ROM output, one cycle after rom_addr sampled
//   cmd_out      out CMD_W      command for the granted lane (held)
//   cmd_valid    out NUM_LANES  one-hot single-cycle delivery strobe
//   list_idx     out ADDR_W     index of next command to fetch
//   score        out 16         saturating hit count
//   busy         out 1          fetch/delivery in progress
//   fim_de_jogo  out 1          list exhausted
module pattern_scheduler
    import pattern_scheduler_pkg::*;
#(
    parameter int NUM_LANES = 3,
    parameter int CMD_W     = CMD_W_DEFAULT,
    parameter int ADDR_W    = 6,
    parameter int LIST_LEN  = 10
) (
    input  logic                 CLOCK_25,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [NUM_LANES-1:0] req,
    input  logic [NUM_LANES-1:0] ponto,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [CMD_W-1:0]     rom_data,
    output logic [CMD_W-1:0]     cmd_out,
    output logic [NUM_LANES-1:0] cmd_valid,
    output logic [ADDR_W-1:0]    list_idx,
    output logic [SCORE_W-1:0]   score,
    output logic                 busy,
    output logic                 fim_de_jogo
);

    localparam int               PTR_W    = $clog2(NUM_LANES);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LIST_LEN - 1);

    sched_state_t           r_state;
    sched_state_t           w_state_next;
    logic [NUM_LANES-1:0]   r_pending;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [PTR_W-1:0]       r_grant;
    logic [ADDR_W-1:0]      r_rom_addr;
    logic [CMD_W-1:0]       r_cmd_out;
    logic [NUM_LANES-1:0]   r_cmd_valid;
    logic [ADDR_W-1:0]      r_list_idx;
    logic [SCORE_W-1:0]     r_score;
    logic                   r_busy;
    logic                   r_fim;

    logic [NUM_LANES-1:0]   w_grant_onehot;
    logic [PTR_W-1:0]       w_grant_idx;
    logic                   w_any_req;
    logic                   w_do_clear;
    logic                   w_do_grant;
    logic                   w_last;
    logic                   w_req_en;
    logic                   w_score_en;
    logic [NUM_LANES-1:0]   w_pending_set;
    logic [NUM_LANES-1:0]   w_pending_clr;
    logic [NUM_LANES-1:0]   w_grant_mask;
    logic [PTR_W-1:0]       w_rr_ptr_next;
    logic [3:0]             w_pop;
    logic [SCORE_W:0]       w_score_sum;
    logic [SCORE_W-1:0]     w_score_next;

    pattern_scheduler_rr_arbiter #(
        .NUM_LANES (NUM_LANES),
        .PTR_W     (PTR_W)
    ) u_rr_arbiter (
        .pending      (r_pending),
        .rr_ptr       (r_rr_ptr),
        .grant_onehot (w_grant_onehot),
        .grant_idx    (w_grant_idx),
        .any_req      (w_any_req)
    );

    // Next-state logic and the single-cycle control strobes of the FSM.
    always_comb begin
        w_state_next = r_state;
        w_do_clear   = 1'b0;
        w_do_grant   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_ARB;
                    w_do_clear   = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (w_any_req) begin
                    w_state_next = ST_READ;
                    w_do_grant   = 1'b1;
                end else begin
                    w_state_next = ST_ARB;
                end
            end
            ST_READ:    w_state_next = ST_LOAD;
            ST_LOAD:    w_state_next = ST_DELIVER;
            ST_DELIVER: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_ARB;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_state_next = ST_ARB;
                    w_do_clear   = 1'b1;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath helpers: request gating, grant masks, pointer wrap, saturating score.
    always_comb begin
        w_last        = (r_list_idx == LAST_IDX);
        w_req_en      = (r_state != ST_IDLE) && (r_state != ST_DONE);
        w_score_en    = w_req_en;
        w_pending_set = req & {NUM_LANES{w_req_en}};
        // grant clears after the set term so a same-cycle request is consumed
        w_pending_clr = w_do_grant ? w_grant_onehot : '0;
        w_grant_mask  = NUM_LANES'(1) << r_grant;
        if (r_grant == PTR_W'(NUM_LANES - 1)) begin
            w_rr_ptr_next = '0;
        end else begin
            w_rr_ptr_next = r_grant + PTR_W'(1);
        end
        w_pop       = popcount8(8'(ponto));
        w_score_sum = {1'b0, r_score} + (SCORE_W+1)'(w_pop);
        if (w_score_sum[SCORE_W]) begin
            w_score_next = '1;
        end else begin
            w_score_next = w_score_sum[SCORE_W-1:0];
        end
    end

    // State register; busy and fim_de_jogo are registered from the next state.
    always_ff @(posedge CLOCK_25) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_fim   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_READ) || (w_state_next == ST_LOAD) ||
                       (w_state_next == ST_DELIVER);
            r_fim   <= (w_state_next == ST_DONE);
        end
    end

    // Pending lanes, round-robin pointer and the latched grant index.
    always_ff @(posedge CLOCK_25) begin
        if (!reset_n) begin
            r_pending <= '0;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
        end else if (w_do_clear) begin
            r_pending <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_pending <= (r_pending | w_pending_set) & ~w_pending_clr;
            if (w_do_grant) begin
                r_grant <= w_grant_idx;
            end
            if (r_state == ST_DELIVER) begin
                r_rr_ptr <= w_rr_ptr_next;
            end
        end
    end

    // ROM address launch, command capture and the delivery strobe.
    always_ff @(posedge CLOCK_25) begin
        if (!reset_n) begin
            r_rom_addr  <= '0;
            r_cmd_out   <= '0;
            r_cmd_valid <= '0;
        end else begin
            if (w_do_grant) begin
                r_rom_addr <= r_list_idx;
            end
            // captured while in LOAD so the strobe is visible exactly in DELIVER
            if (r_state == ST_LOAD) begin
                r_cmd_out   <= rom_data;
                r_cmd_valid <= w_grant_mask;
            end else begin
                r_cmd_valid <= '0;
            end
        end
    end

    // List position and score accumulation.
    always_ff @(posedge CLOCK_25) begin
        if (!reset_n) begin
            r_list_idx <= '0;
            r_score    <= '0;
        end else if (w_do_clear) begin
            r_list_idx <= '0;
            r_score    <= '0;
        end else begin
            if ((r_state == ST_DELIVER) && !w_last) begin
                r_list_idx <= r_list_idx + ADDR_W'(1);
            end
            if (w_score_en) begin
                r_score <= w_score_next;
            end
        end
    end

    assign rom_addr    = r_rom_addr;
    assign cmd_out     = r_cmd_out;
    assign cmd_valid   = r_cmd_valid;
    assign list_idx    = r_list_idx;
    assign score       = r_score;
    assign busy        = r_busy;
    assign fim_de_jogo = r_fim;

endmodule

// File: tb/tb_pattern_scheduler.sv
module tb_pattern_scheduler;

    logic        CLOCK_25 = 1'b0;
    logic        reset_n  = 1'b0;
    logic        start    = 1'b0;
    logic [2:0]  req      = 3'b000;
    logic [2:0]  ponto    = 3'b000;
    logic [5:0]  rom_addr;
    logic [3:0]  rom_data = 4'h0;
    logic [3:0]  cmd_out;
    logic [2:0]  cmd_valid;
    logic [5:0]  list_idx;
    logic [15:0] score;
    logic        busy;
    logic        fim_de_jogo;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        logic [2:0] lane;
        logic [3:0] cmd;
        int         at;
    } exp_t;
    exp_t sb_q[$];

    pattern_scheduler #(
        .NUM_LANES (3),
        .CMD_W     (4),
        .ADDR_W    (6),
        .LIST_LEN  (10)
    ) dut (
        .CLOCK_25    (CLOCK_25),
        .reset_n     (reset_n),
        .start       (start),
        .req         (req),
        .ponto       (ponto),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .cmd_out     (cmd_out),
        .cmd_valid   (cmd_valid),
        .list_idx    (list_idx),
        .score       (score),
        .busy        (busy),
        .fim_de_jogo (fim_de_jogo)
    );

    always #20 CLOCK_25 = ~CLOCK_25;

    always @(posedge CLOCK_25) cyc <= cyc + 1;

    // Command ROM contents (list of 10 plus filler)
    function automatic logic [3:0] rom_val(input logic [5:0] a);
        case (a)
            6'd0: return 4'h5;
            6'd1: return 4'hA;
            6'd2: return 4'h3;
            6'd3: return 4'hC;
            6'd4: return 4'h7;
            6'd5: return 4'h1;
            6'd6: return 4'hE;
            6'd7: return 4'h9;
            6'd8: return 4'h2;
            6'd9: return 4'hB;
            default: return 4'hF;
        endcase
    endfunction

    // Synchronous ROM model
    always @(posedge CLOCK_25) rom_data <= rom_val(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_25);
        #1;
    endtask

    task automatic expect_cmd(input logic [2:0] lane, input logic [3:0] cmd, input int at);
        exp_t e;
        e.lane = lane;
        e.cmd  = cmd;
        e.at   = at;
        sb_q.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge CLOCK_25);
            if (cmd_valid !== 3'b000) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_cmd_valid", {29'd0, cmd_valid}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("deliver_lane", {29'd0, cmd_valid}, {29'd0, e.lane});
                    check("deliver_cmd", {28'd0, cmd_out}, {28'd0, e.cmd});
                    check("deliver_cycle", cyc, e.at);
                end
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int k;
        fork
            monitor();
        join_none

        // Reset values
        repeat (3) tick();
        check("rst_rom_addr", {26'd0, rom_addr}, 32'd0);
        check("rst_cmd_out", {28'd0, cmd_out}, 32'd0);
        check("rst_cmd_valid", {29'd0, cmd_valid}, 32'd0);
        check("rst_list_idx", {26'd0, list_idx}, 32'd0);
        check("rst_score", {16'd0, score}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fim", {31'd0, fim_de_jogo}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Single request on lane 0 -> ROM[0]=5 four cycles later
        do_start();
        req = 3'b001;
        k = cyc;
        expect_cmd(3'b001, 4'h5, k + 4);
        tick();
        req = 3'b000;
        repeat (6) tick();
        check("t1_list_idx", {26'd0, list_idx}, 32'd1);
        check("t1_cmd_hold", {28'd0, cmd_out}, 32'h5);

        // Simultaneous requests from rr_ptr=0 -> lanes 0,1,2
        do_reset();
        do_start();
        req = 3'b111;
        k = cyc;
        expect_cmd(3'b001, 4'h5, k + 4);
        expect_cmd(3'b010, 4'hA, k + 8);
        expect_cmd(3'b100, 4'h3, k + 12);
        tick();
        req = 3'b000;
        repeat (20) tick();
        check("t2_busy_idle", {31'd0, busy}, 32'd0);
        check("t2_list_idx", {26'd0, list_idx}, 32'd3);

        // Full list with continuous requests; score from ponto=101 x5
        do_reset();
        do_start();
        req   = 3'b111;
        ponto = 3'b101;
        k = cyc;
        expect_cmd(3'b001, 4'h5, k + 4);
        expect_cmd(3'b010, 4'hA, k + 8);
        expect_cmd(3'b100, 4'h3, k + 12);
        expect_cmd(3'b001, 4'hC, k + 16);
        expect_cmd(3'b010, 4'h7, k + 20);
        expect_cmd(3'b100, 4'h1, k + 24);
        expect_cmd(3'b001, 4'hE, k + 28);
        expect_cmd(3'b010, 4'h9, k + 32);
        expect_cmd(3'b100, 4'h2, k + 36);
        expect_cmd(3'b001, 4'hB, k + 40);
        repeat (5) tick();
        ponto = 3'b000;
        check("t3_score_10", {16'd0, score}, 32'd10);
        repeat (35) tick();
        check("t3_fim_before", {31'd0, fim_de_jogo}, 32'd0);
        tick();
        check("t3_fim_after", {31'd0, fim_de_jogo}, 32'd1);
        check("t3_list_idx", {26'd0, list_idx}, 32'd9);
        check("t3_busy_done", {31'd0, busy}, 32'd0);
        ponto = 3'b111;
        repeat (5) tick();
        ponto = 3'b000;
        check("t3_score_frozen", {16'd0, score}, 32'd10);
        repeat (10) tick();
        req = 3'b000;
        check("t3_list_idx_held", {26'd0, list_idx}, 32'd9);
        check("t3_fim_held", {31'd0, fim_de_jogo}, 32'd1);

        // Restart from DONE
        do_start();
        check("t4_list_idx", {26'd0, list_idx}, 32'd0);
        check("t4_score", {16'd0, score}, 32'd0);
        check("t4_fim", {31'd0, fim_de_jogo}, 32'd0);
        req = 3'b010;
        k = cyc;
        expect_cmd(3'b010, 4'h5, k + 4);
        tick();
        req = 3'b000;
        repeat (6) tick();
        check("t4_list_idx_after", {26'd0, list_idx}, 32'd1);

        // Reset while in LOAD aborts the fetch
        req = 3'b001;
        tick();
        req = 3'b000;
        tick();
        tick();
        check("t5_busy_in_load", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("t5_cmd_valid", {29'd0, cmd_valid}, 32'd0);
        check("t5_cmd_out", {28'd0, cmd_out}, 32'd0);
        check("t5_rom_addr", {26'd0, rom_addr}, 32'd0);
        check("t5_list_idx", {26'd0, list_idx}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        req = 3'b001;
        tick();
        req = 3'b000;
        repeat (10) tick();
        check("t5_no_start_busy", {31'd0, busy}, 32'd0);
        do_start();
        req = 3'b100;
        k = cyc;
        expect_cmd(3'b100, 4'h5, k + 4);
        tick();
        req = 3'b000;
        repeat (6) tick();
        check("t5_list_idx_after", {26'd0, list_idx}, 32'd1);

        // Score saturation: +3 per cycle in ARB
        ponto = 3'b111;
        repeat (21844) tick();
        check("t6_score_near", {16'd0, score}, 32'd65532);
        tick();
        check("t6_score_max", {16'd0, score}, 32'd65535);
        repeat (2) tick();
        ponto = 3'b000;
        check("t6_score_sat", {16'd0, score}, 32'd65535);

        repeat (4) tick();
        check("sb_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pattern_scheduler.md
Name: pattern_scheduler

Overview:
- Sequences the shared pattern-command list among the falling-note lanes.
- Each lane pulses a request (trocar) when its pattern leaves the screen. The scheduler arbitrates round-robin, reads the next command from a synchronous command ROM, and delivers it to exactly one lane.
- Tracks list position, raises fim_de_jogo at list end, and accumulates hit points (ponto) into a score.
- Sits between the pattern lanes and the command ROM, replacing direct list stepping.

Parameters:
- NUM_LANES, 3, number of requesting pattern lanes (2..8).
- CMD_W, 4, command word width.
- ADDR_W, 6, ROM address width.
- LIST_LEN, 10, number of commands in the list (1..2^ADDR_W).

Ports:
- CLOCK_25  in  1  system clock (25 MHz pixel clock domain).
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  begin/restart a game; sampled in IDLE or DONE only.
- req  in  NUM_LANES  per-lane request pulses (trocar).
- ponto  in  NUM_LANES  per-lane hit pulses.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_data  in  CMD_W  ROM output, valid the cycle after rom_addr is sampled.
- cmd_out  out  CMD_W  command for the granted lane, registered.
- cmd_valid  out  NUM_LANES  one-hot, single-cycle delivery strobe.
- list_idx  out  ADDR_W  index of the next command to fetch.
- score  out  16  saturating hit count.
- busy  out  1  high in READ/LOAD/DELIVER.
- fim_de_jogo  out  1  high in DONE.

Behaviour:
- Clock and reset: one clock, CLOCK_25. reset_n is synchronous and active-low; all state updates on the rising edge of CLOCK_25.
- Values when reset_n=0:
  - State IDLE.
  - pending=0, rr_ptr=0, grant=0.
  - rom_addr=0, cmd_out=0, cmd_valid=0.
  - list_idx=0, score=0, busy=0, fim_de_jogo=0.
- Reset asserted mid-operation aborts any fetch; no cmd_valid is produced afterwards.
- Pending register, one bit per lane:
  - Set on req[i]=1 while not in IDLE or DONE.
  - Cleared when lane i is granted.
  - req on an already-pending lane has no further effect; requests are not counted.
  - req in the same cycle the lane is granted: the grant wins; the request is consumed and pending stays 0.
  - req on the granted lane during READ/LOAD/DELIVER sets pending again.
- States:
  - IDLE: if start, clear list_idx, score, pending and rr_ptr, then go to ARB.
  - ARB: if pending!=0, grant = first set bit searching upward from rr_ptr with wrap-around; rom_addr<=list_idx; clear pending[grant]; go to READ. Otherwise stay in ARB.
  - READ: the ROM samples rom_addr; go to LOAD.
  - LOAD: cmd_out<=rom_data; go to DELIVER.
  - DELIVER: cmd_valid=onehot(grant) for exactly this cycle; rr_ptr<=(grant+1) mod NUM_LANES.
    - If list_idx==LIST_LEN-1, go to DONE.
    - Else list_idx<=list_idx+1 and go to ARB.
  - DONE: fim_de_jogo=1; req is ignored; list_idx is held; start returns to IDLE-style clear and goes to ARB.
- Latency:
  - From req high in cycle c with the FSM idle in ARB: pending set at edge c, grant at edge c+1, cmd_valid high in cycle c+4.
  - Back-to-back service: one command per 4 cycles.
- cmd_out holds its last value between deliveries.
- start is ignored in ARB/READ/LOAD/DELIVER.
- Score:
  - While in ARB..DONE but not DONE, score += popcount(ponto) each cycle.
  - Saturates at 16'hFFFF.
  - Frozen in IDLE and DONE.
  - Cleared only by reset or start.

Decomposition:
- Shared package holds:
  - the state enumeration (IDLE, ARB, READ, LOAD, DELIVER, DONE);
  - the default CMD_W;
  - the SCORE_W=16 constant.
- One sub-module: rr_arbiter (combinational). Inputs pending and rr_ptr; outputs a one-hot grant and its index plus any_req.
- FSM, counters and score stay in pattern_scheduler.

Test Plan:
- Reset, then start; req=3'b001 in cycle c; ROM[0]=4'h5 → cmd_valid=3'b001 in c+4 with cmd_out=4'h5; list_idx then 1.
- Simultaneous req=3'b111 from rr_ptr=0 → deliveries go to lanes 0, 1, 2 in that order, 4 cycles apart, carrying ROM[0..2]; pending=0 at the end.
- LIST_LEN=10 with continuous requests → exactly 10 cmd_valid pulses. fim_de_jogo rises the cycle after the 10th pulse; further req produce nothing; list_idx=9.
- ponto=3'b101 held for 5 cycles while running → score=10. score preloaded near 16'hFFFE saturates at 16'hFFFF. score is unchanged in DONE.
- reset_n=0 for one cycle while in LOAD → no cmd_valid follows; all outputs return to reset values; start is then required to resume.
- start in DONE → list_idx=0, score=0, fim_de_jogo=0; the next req fetches ROM[0].
